// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the register-file write-port logic: default geometry
// of the register file and the state encoding of the write sequencer.
// Ports: none (package).
package regfile_pkg;

   localparam int DEF_NUM_REGS = 17;   // registers implemented, addresses 0..DEF_NUM_REGS-1
   localparam int DEF_ADDR_W   = 5;    // register address width
   localparam int DEF_DATA_W   = 32;   // register data width

   // Write sequencer states: clear sweep after reset, then arbitration.
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_ARB  = 1'b1
   } wrState_e;

endpackage : regfile_pkg

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-requester round-robin arbiter with a one-hot, combinational grant.
// After every grant the pointer moves to favour the requester that lost, so
// two continuously valid requesters alternate and neither waits more than
// one cycle.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous, active-high; pointer returns to requester 0
//   enable  in   grants are only issued while high
//   valid   in   [1:0] request lines
//   grant   out  [1:0] one-hot grant (all zero when nothing is granted)
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [1:0] valid,
   output logic [1:0] grant
);

   logic ptr_r;   // 1'b0 favours requester 0, 1'b1 favours requester 1

   // Grant decode: a lone requester always wins, a tie goes to the pointer.
   always_comb begin
      grant = 2'b00;
      if (enable) begin
         grant[0] = valid[0] && (!valid[1] || (ptr_r == 1'b0));
         grant[1] = valid[1] && (!valid[0] || (ptr_r == 1'b1));
      end else begin
         grant = 2'b00;
      end
   end

   // Pointer update: favour whichever requester did not just win.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_r <= 1'b0;
      end else if (grant[0]) begin
         ptr_r <= 1'b1;
      end else if (grant[1]) begin
         ptr_r <= 1'b0;
      end else begin
         ptr_r <= ptr_r;
      end
   end

endmodule : rr_arbiter2

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
// Owns the single write port of the register file. After reset it sweeps
// every implemented register and writes zero; afterwards it shares the port
// between the ALU writeback (requester 0) and the load writeback
// (requester 1) with round-robin arbitration. Writes to r0 are accepted but
// suppressed; writes beyond the implemented range are accepted, suppressed
// and flagged with a one-cycle err_addr pulse.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   reqN_valid/reg/data   in    requester N write request (held until ready)
//   reqN_ready            out   requester N accepted this cycle (combinational)
//   regWr/wrReg/wrData    out   registered register-file write port
//   init_done             out   high once the clear sweep has finished
//   err_addr              out   one-cycle pulse on an out-of-range write
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_reg,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_reg,
   input  logic [DATA_W-1:0] req1_data,
   output logic              regWr,
   output logic [ADDR_W-1:0] wrReg,
   output logic [DATA_W-1:0] wrData,
   output logic              init_done,
   output logic              err_addr
);

   // One extra bit so the comparison also works when NUM_REGS == 2**ADDR_W.
   localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST_REG   = ADDR_W'(NUM_REGS - 1);

   wrState_e          state_r;
   logic [ADDR_W-1:0] sweepCnt_r;
   logic              arbEn_s;
   logic [1:0]        grant_s;
   logic              anyGrant_s;
   logic [ADDR_W-1:0] selReg_s;
   logic [DATA_W-1:0] selData_s;
   logic              addrOob_s;
   logic              addrZero_s;

   assign arbEn_s = (state_r == ST_ARB);

   rr_arbiter2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .enable (arbEn_s),
      .valid  ({req1_valid, req0_valid}),
      .grant  (grant_s)
   );

   assign req0_ready = grant_s[0];
   assign req1_ready = grant_s[1];
   assign anyGrant_s = grant_s[0] || grant_s[1];

   // Select the winning request and classify its destination address.
   always_comb begin
      selReg_s   = req0_reg;
      selData_s  = req0_data;
      if (grant_s[1]) begin
         selReg_s  = req1_reg;
         selData_s = req1_data;
      end else begin
         selReg_s  = req0_reg;
         selData_s = req0_data;
      end
      addrOob_s  = ({1'b0, selReg_s} >= NUM_REGS_W);
      addrZero_s = (selReg_s == {ADDR_W{1'b0}});
   end

   // Sequencer: clear sweep, then registered write port driven by the grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_INIT;
         sweepCnt_r <= {ADDR_W{1'b0}};
         regWr      <= 1'b0;
         wrReg      <= {ADDR_W{1'b0}};
         wrData     <= {DATA_W{1'b0}};
         init_done  <= 1'b0;
         err_addr   <= 1'b0;
      end else begin
         case (state_r)
            ST_INIT: begin
               regWr      <= 1'b1;
               wrReg      <= sweepCnt_r;
               wrData     <= {DATA_W{1'b0}};
               init_done  <= 1'b0;
               err_addr   <= 1'b0;
               sweepCnt_r <= sweepCnt_r + ADDR_W'(1);
               if (sweepCnt_r == LAST_REG) begin
                  state_r <= ST_ARB;
               end else begin
                  state_r <= ST_INIT;
               end
            end
            ST_ARB: begin
               state_r   <= ST_ARB;
               init_done <= 1'b1;
               if (anyGrant_s && addrOob_s) begin
                  // Accepted but unimplemented: drop it and flag.
                  regWr    <= 1'b0;
                  err_addr <= 1'b1;
               end else if (anyGrant_s && !addrZero_s) begin
                  regWr    <= 1'b1;
                  wrReg    <= selReg_s;
                  wrData   <= selData_s;
                  err_addr <= 1'b0;
               end else begin
                  // Idle, or an accepted write to r0 which must stay zero.
                  regWr    <= 1'b0;
                  err_addr <= 1'b0;
               end
            end
            default: begin
               state_r    <= ST_INIT;
               sweepCnt_r <= {ADDR_W{1'b0}};
               regWr      <= 1'b0;
               init_done  <= 1'b0;
               err_addr   <= 1'b0;
            end
         endcase
      end
   end

endmodule : regfile_wr_arbiter

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Sequencer and arbiter for the single write port of the 32-bit register file. After reset it walks every register and writes zero; it then shares the write port between two writeback requesters (ALU writeback, load writeback) with fair round-robin arbitration. It sits between the pipeline writeback stages and the register file's `regWr`/`wrReg`/`wrData` inputs.

## Interface
Parameters:
- `NUM_REGS`, default 17: registers implemented; valid addresses are 0..NUM_REGS-1.
- `ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 (ALU) has a write pending.
- `req0_ready`  out  1  requester 0 write accepted this cycle.
- `req0_reg`  in  ADDR_W  requester 0 destination register.
- `req0_data`  in  DATA_W  requester 0 write data.
- `req1_valid`, `req1_ready`, `req1_reg`, `req1_data`: same as above, for requester 1 (load).
- `regWr`  out  1  register file write enable (registered).
- `wrReg`  out  ADDR_W  register file write address (registered).
- `wrData`  out  DATA_W  register file write data (registered).
- `init_done`  out  1  high once the clear sweep has completed.
- `err_addr`  out  1  one-cycle pulse: an accepted write targeted an address ≥ NUM_REGS.

## Operation
- Two states: INIT and ARB.
- On `reset`: state=INIT, sweep counter=0, `regWr`=0, `wrReg`=0, `wrData`=0, `init_done`=0, `err_addr`=0, round-robin pointer=0 (requester 0 favoured). Both readies are 0.
- INIT: each cycle, register `regWr`=1, `wrReg`=counter, `wrData`=0, then increment the counter. When the counter equals NUM_REGS-1, go to ARB. Both readies stay 0 throughout INIT.
- ARB, acceptance rules:
  - `reqN_ready` = ARB && `reqN_valid` && (the other requester is not valid || pointer favours N).
  - Readies are combinational; a requester must hold valid, reg and data stable until it sees ready.
- Pointer: after any grant, the pointer moves to favour the non-granted requester. It is unchanged when nothing is granted.
- Accepted write, address 1..NUM_REGS-1: next cycle `regWr`=1, with the accepted reg and data.
- Accepted write to register 0: accepted, but next cycle `regWr`=0 (r0 stays zero).
- Accepted write to an address ≥ NUM_REGS: accepted, `regWr`=0, and `err_addr`=1 for one cycle.
- No acceptance: next cycle `regWr`=0. `wrReg`/`wrData` hold their previous values.
- Reset during ARB or mid-INIT restarts the sweep from address 0. Any write accepted in the same cycle as reset is dropped.

## Timing
- Write latency: acceptance in cycle t gives `regWr` high in cycle t+1. There is one write per cycle at most.
- Sweep timing, taking cycle 0 as the first edge with `reset` low:
  - `wrReg` runs 0..NUM_REGS-1 on edges 0..NUM_REGS-1.
  - `init_done` rises at edge NUM_REGS.
  - A ready can first be high in the cycle after edge NUM_REGS-1.
- Throughput: 1 write/cycle sustained. With both requesters valid every cycle, grants alternate 0,1,0,1...
- Starvation bound: a valid requester waits at most 1 cycle once in ARB.

## Structure
- Shared package `regfile_pkg`: `ADDR_W`, `DATA_W` and `NUM_REGS` defaults, and the state enum (INIT, ARB).
- One sub-module, `rr_arbiter2`: two valids in, one-hot grant out, and the pointer register with its update. It is reusable for the read-port sharing that comes next.
- Counter, output registers and error pulse live in the top module.

## Test plan
- Reset held 3 cycles, then released → `regWr`=1 with `wrReg`=0..16 and `wrData`=0 on 17 consecutive edges; `init_done` rises at edge 17; no ready during the sweep.
- After init, req0 only with reg=5, data=0xDEADBEEF → `req0_ready`=1 the same cycle; the next cycle has `regWr`=1, `wrReg`=5, `wrData`=0xDEADBEEF.
- Both requesters valid for 4 cycles (req0 to r1/r2/..., req1 to r9/r10/...) → grants go 0,1,0,1, and the `wrReg` sequence is 1,9,2,10.
- req1 writes reg=0 with data=0x1, then reg=20 → both accepted; `regWr`=0 for both; `err_addr` pulses only on the second.
- Reset asserted for 1 cycle while both requesters are valid in ARB → readies drop; the sweep restarts at `wrReg`=0; the write accepted in the reset cycle never appears on `regWr`.
- Random valids for 10k cycles against a reference model → every accepted write appears exactly once, in order, one cycle later; no requester waits more than 1 cycle.
